// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining four FWFT input FIFOs into one output FIFO,
// serving up to BURST consecutive words per grant with no bubble on rotation.
//
// state | meaning
// IDLE  | no FIFO granted; next grant searches after 'last'
// SERVE | FIFO 'cur' granted, 'count' words popped in this burst
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int BURST      = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pause,
  input  logic                  empty_fifo_0,
  input  logic                  empty_fifo_1,
  input  logic                  empty_fifo_2,
  input  logic                  empty_fifo_3,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic                  push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t                  state, state_nxt;
  logic [1:0]              cur, cur_nxt;
  logic [1:0]              last, last_nxt;
  logic [CNT_W-1:0]        count, count_nxt;
  logic                    go;
  logic [3:0]              elig;
  logic                    take;
  logic [1:0]              take_idx;
  logic [2:0]              pick;
  logic [DATA_WIDTH-1:0]   take_data;

  // {found, index} of first eligible FIFO after p, with p itself checked last
  function automatic logic [2:0] next_pick(input logic [1:0] p, input logic [3:0] el);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (el[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    go   = enable & ~pause & reset;
    elig = ~{empty_fifo_3, empty_fifo_2, empty_fifo_1, empty_fifo_0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cur   <= 2'd0;
      last  <= 2'd3;
      count <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      last  <= last_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    last_nxt  = last;
    count_nxt = count;
    take      = 1'b0;
    take_idx  = cur;
    pick      = 3'b000;
    if (go) begin
      case (state)
        IDLE: begin
          pick = next_pick(last, elig);
          if (pick[2]) begin
            take      = 1'b1;
            take_idx  = pick[1:0];
            cur_nxt   = pick[1:0];
            count_nxt = ONE_C;
            state_nxt = SERVE;
          end
        end
        SERVE: begin
          if (count < BURST_C && elig[cur]) begin
            take      = 1'b1;
            take_idx  = cur;
            count_nxt = count + ONE_C;
          end else begin
            // burst over or source dried up: hand over in the same cycle
            last_nxt = cur;
            pick     = next_pick(cur, elig);
            if (pick[2]) begin
              take      = 1'b1;
              take_idx  = pick[1:0];
              cur_nxt   = pick[1:0];
              count_nxt = ONE_C;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    pop_0 = take && (take_idx == 2'd0);
    pop_1 = take && (take_idx == 2'd1);
    pop_2 = take && (take_idx == 2'd2);
    pop_3 = take && (take_idx == 2'd3);
    busy  = (state == SERVE);
    case (take_idx)
      2'd0:    take_data = data_in_0;
      2'd1:    take_data = data_in_1;
      2'd2:    take_data = data_in_2;
      default: take_data = data_in_3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      push_out <= 1'b0;
      data_out <= '0;
      grant    <= 2'd0;
    end else if (take) begin
      push_out <= 1'b1;
      data_out <= take_data;
      grant    <= take_idx;
    end else begin
      push_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: queue-backed FIFOs, directed scenarios and random
// traffic, every cycle compared against a queue-level round-robin model.
module tb_fifo_rr_arbiter;
  localparam int DW    = 6;
  localparam int BURST = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset, enable, pause;
  logic          empty_fifo_0, empty_fifo_1, empty_fifo_2, empty_fifo_3;
  logic [DW-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic          pop_0, pop_1, pop_2, pop_3;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant;
  logic          busy;

  fifo_rr_arbiter #(.DATA_WIDTH(DW), .BURST(BURST), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause),
    .empty_fifo_0(empty_fifo_0), .empty_fifo_1(empty_fifo_1),
    .empty_fifo_2(empty_fifo_2), .empty_fifo_3(empty_fifo_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .data_in_3(data_in_3),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push_out(push_out), .data_out(data_out), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // input FIFO contents, head at index 0
  logic [DW-1:0] fq [4][$];

  // reference model: owner of the current burst, words served, previous owner
  bit            m_busy  = 1'b0;
  int            m_cur   = 0;
  int            m_last  = 3;
  int            m_cnt   = 0;
  logic          m_push  = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_grant = 0;

  function automatic int pick_after(input int p);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (p + i) % 4;
      if (fq[k].size() != 0) return k;
    end
    return -1;
  endfunction

  function automatic int decide(input bit go);
    if (!go) return -1;
    if (!m_busy) return pick_after(m_last);
    if (m_cnt < BURST && fq[m_cur].size() != 0) return m_cur;
    return pick_after(m_cur);
  endfunction

  task automatic drive_fifos();
    empty_fifo_0 = (fq[0].size() == 0);
    empty_fifo_1 = (fq[1].size() == 0);
    empty_fifo_2 = (fq[2].size() == 0);
    empty_fifo_3 = (fq[3].size() == 0);
    data_in_0 = (fq[0].size() != 0) ? fq[0][0] : DW'($urandom);
    data_in_1 = (fq[1].size() != 0) ? fq[1][0] : DW'($urandom);
    data_in_2 = (fq[2].size() != 0) ? fq[2][0] : DW'($urandom);
    data_in_3 = (fq[3].size() != 0) ? fq[3][0] : DW'($urandom);
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) fq[k].push_back(DW'($urandom));
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) fq[k].delete();
  endtask

  task automatic cycle(input bit rst_n, input bit en, input bit pa);
    int         e;
    bit         go;
    logic [3:0] popv, expv, empv;
    @(negedge clk);
    reset  = rst_n;
    enable = en;
    pause  = pa;
    drive_fifos();
    #1;
    go   = rst_n && en && !pa;
    e    = decide(go);
    popv = {pop_3, pop_2, pop_1, pop_0};
    empv = {empty_fifo_3, empty_fifo_2, empty_fifo_1, empty_fifo_0};
    expv = (e >= 0) ? 4'(1 << e) : 4'b0000;
    chk("pop", 32'(popv), 32'(expv));
    chk("pop_empty", 32'(popv & empv), 32'd0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 1'b0; m_cur = 0; m_last = 3; m_cnt = 0;
      m_push = 1'b0; m_data = '0; m_grant = 0;
    end else begin
      if (go) begin
        if (!m_busy) begin
          if (e >= 0) begin m_busy = 1'b1; m_cur = e; m_cnt = 1; end
        end else if (m_cnt < BURST && fq[m_cur].size() != 0) begin
          m_cnt++;
        end else begin
          m_last = m_cur;
          if (e >= 0) begin m_cur = e; m_cnt = 1; end
          else m_busy = 1'b0;
        end
      end
      m_push = (e >= 0);
      if (e >= 0) begin
        m_data  = fq[e][0];
        m_grant = e;
        void'(fq[e].pop_front());
      end
    end
    chk("push_out", 32'(push_out), 32'(m_push));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("grant",    32'(grant),    32'(m_grant));
    chk("busy",     32'(busy),     32'(m_busy));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; pause = 1'b0;
    drive_fifos();

    // reset with every FIFO holding data
    for (int k = 0; k < 4; k++) load(k, 3);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    chk("rst_push", 32'(push_out), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);

    // single source: six words only in FIFO 2
    clear_all();
    load(2, 6);
    repeat (9) cycle(1'b1, 1'b1, 1'b0);

    // fair rotation with all FIFOs busy
    clear_all();
    for (int k = 0; k < 4; k++) load(k, 10);
    repeat (18) cycle(1'b1, 1'b1, 1'b0);

    // pause in the middle of a burst on FIFO 1
    clear_all();
    cycle(1'b0, 1'b1, 1'b0);
    load(1, 8); load(2, 4);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // early empty: FIFO 0 one word, FIFO 3 three words
    clear_all();
    cycle(1'b0, 1'b1, 1'b0);
    load(0, 1); load(3, 3);
    repeat (6) cycle(1'b1, 1'b1, 1'b0);

    // reset during a burst on FIFO 2
    clear_all();
    cycle(1'b0, 1'b1, 1'b0);
    load(2, 8); load(0, 2);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0);

    // random traffic, pause/enable and occasional reset
    clear_all();
    for (int n = 0; n < 3000; n++) begin
      bit r, en, pa;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 99) < 22 && fq[k].size() < 12) load(k, $urandom_range(1, 3));
      r  = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) != 0);
      pa = ($urandom_range(0, 4) == 0);
      cycle(r, en, pa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
